// File: rtl/mioc_deser_if.sv
// Handshake and status bundle between the MIOC serial source, mioc_deser and the flop bank.
interface mioc_deser_if #(parameter int WIDTH = 8);
  logic             sdi;
  logic             sen;
  logic             dack;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             busy;
  logic             ferr;
  logic             perr;
  logic             ovr;

  modport master (output sdi, sen, dack, input dout, dvalid, busy, ferr, perr, ovr);
  modport slave  (input sdi, sen, dack, output dout, dvalid, busy, ferr, perr, ovr);
endinterface

// File: rtl/mioc_deser.sv
// Falling-edge start/data/[parity]/stop frame receiver with valid/ack word output and sticky flags.
// Parity bit and PAR state are present only when MIOC_DESER_PARITY_EN is defined.
module mioc_deser #(
  parameter int WIDTH = 8
) (
  input logic         in2,
  input logic         in1,
  mioc_deser_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef MIOC_DESER_PARITY_EN
    PAR   = 2'd2,
`endif
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;
  logic             deliver;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ferr_d   = ferr_q;
    perr_d   = perr_q;
    ovr_d    = ovr_q;
    deliver  = 1'b0;

    if (bus.sen) begin
      case (state_q)
        IDLE: begin
          if (!bus.sdi) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sreg_d  = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
        SHIFT: begin
          sreg_d[cnt_q] = bus.sdi;
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef MIOC_DESER_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef MIOC_DESER_PARITY_EN
        PAR: begin
          // Even parity: data plus parity bit must hold an even count of ones.
          if (^{sreg_q, bus.sdi}) perr_d = 1'b1;
          state_d = STOP;
        end
`endif
        STOP: begin
          state_d = IDLE;
          if (!bus.sdi)     ferr_d  = 1'b1;
          else if (!perr_q) deliver = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Ack on a delivery edge retires the old word so the new one replaces it.
    if (bus.dack) ovr_d = 1'b0;
    if (deliver) begin
      if (!dvalid_q || bus.dack) begin
        dout_d   = sreg_q;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (bus.dack) begin
      dvalid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(negedge in2) begin
    if (!in1) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.busy   = busy_q;
  assign bus.ferr   = ferr_q;
  assign bus.perr   = perr_q;
  assign bus.ovr    = ovr_q;

endmodule

// File: tb/tb_mioc_deser.sv
// Bench for mioc_deser: directed frame scenarios, then random frames scored against a word queue
// consumed by a monitor that acts as the flop bank.
module tb_mioc_deser;
  localparam int W = 8;

  logic in2 = 1'b0;
  logic in1 = 1'b0;
  logic dack_dir = 1'b0;
  logic dack_mon = 1'b0;
  logic rnd_mode = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  mioc_deser_if #(.WIDTH(W)) bus ();
  mioc_deser #(.WIDTH(W)) dut (.in2(in2), .in1(in1), .bus(bus));

  assign bus.dack = rnd_mode ? dack_mon : dack_dir;

  always #5 in2 = ~in2;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic s, input logic e);
    bus.sdi = s;
    bus.sen = e;
    @(negedge in2);
    #1;
  endtask

  task automatic maybe_stall(input int pct);
    if (int'($urandom_range(99)) < pct) tick(1'($urandom_range(1)), 1'b0);
  endtask

  task automatic send(input logic [W-1:0] w, input logic stop_b, input logic par_flip,
                      input int stall_pct, input logic ack_stop);
    tick(1'b0, 1'b1);
    for (int i = 0; i < W; i++) begin
      maybe_stall(stall_pct);
      tick(w[i], 1'b1);
    end
`ifdef MIOC_DESER_PARITY_EN
    maybe_stall(stall_pct);
    tick((^w) ^ par_flip, 1'b1);
`else
    if (par_flip) tick(1'b1, 1'b0);
`endif
    maybe_stall(stall_pct);
    dack_dir = ack_stop;
    tick(stop_b, 1'b1);
    dack_dir = 1'b0;
  endtask

  task automatic ack_one();
    dack_dir = 1'b1;
    tick(1'b1, 1'b0);
    dack_dir = 1'b0;
  endtask

  // Flop-bank model for the random phase: takes each presented word once, acks on the next edge.
  always @(posedge in2) begin
    logic [W-1:0] e;
    if (rnd_mode) begin
      if (bus.dvalid && !dack_mon) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_word: got word %0h, required no word", bus.dout);
        end else begin
          e = exp_q.pop_front();
          if (bus.dout !== e) begin
            fails++;
            $display("FAIL sb_word: got %0h, required %0h", bus.dout, e);
          end
        end
        dack_mon = 1'b1;
      end else begin
        dack_mon = 1'b0;
      end
    end
  end

  initial begin
    logic [W-1:0] w;
    logic bad, flip;
    logic [7:0] a5;
    bus.sdi = 1'b1;
    bus.sen = 1'b0;

    // Reset state
    in1 = 1'b0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    in1 = 1'b1;
    chk("rst_dout", bus.dout, 0);
    chk("rst_dvalid", bus.dvalid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_flags", {bus.ferr, bus.perr, bus.ovr}, 0);

    // Reset mid-frame
    tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    chk("mid_busy", bus.busy, 1);
    in1 = 1'b0;
    tick(1'b0, 1'b1);
    in1 = 1'b1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_out", {bus.dout, bus.dvalid, bus.ferr, bus.perr, bus.ovr}, 0);
    send(8'h3C, 1'b1, 1'b0, 0, 1'b0);
    chk("f3c_dout", bus.dout, 8'h3C);
    chk("f3c_dvalid", bus.dvalid, 1);
    chk("f3c_flags", {bus.ferr, bus.perr, bus.ovr, bus.busy}, 0);
    ack_one();
    chk("f3c_ack_dvalid", bus.dvalid, 0);
    chk("f3c_ack_dout", bus.dout, 8'h3C);

    // Clean 0xA5 frame, sen low on every other edge
    a5 = 8'hA5;
    chk("a5_idle_busy", bus.busy, 0);
    tick(1'b0, 1'b1);
    chk("a5_start_busy", bus.busy, 1);
    for (int i = 0; i < W; i++) begin
      tick(~a5[i], 1'b0);
      chk("a5_stall_busy", bus.busy, 1);
      tick(a5[i], 1'b1);
      chk("a5_bit_dvalid", bus.dvalid, 0);
    end
    tick(1'b0, 1'b0);
    chk("a5_prestop_busy", bus.busy, 1);
    tick(1'b1, 1'b1);
    chk("a5_dout", bus.dout, 8'hA5);
    chk("a5_dvalid", bus.dvalid, 1);
    chk("a5_busy", bus.busy, 0);
    tick(1'b0, 1'b0);
    chk("a5_stall_idle", {bus.busy, bus.dvalid}, 2'b01);
    ack_one();

    // Framing error
    send(8'h5A, 1'b0, 1'b0, 0, 1'b0);
    chk("fe_ferr", bus.ferr, 1);
    chk("fe_dvalid", bus.dvalid, 0);
    chk("fe_dout", bus.dout, 8'hA5);
    tick(1'b0, 1'b1);
    chk("fe_clear", bus.ferr, 0);
    w = 8'h66;
    for (int i = 0; i < W; i++) tick(w[i], 1'b1);
`ifdef MIOC_DESER_PARITY_EN
    tick(^w, 1'b1);
`endif
    tick(1'b1, 1'b1);
    chk("fe_next_dout", bus.dout, 8'h66);
    ack_one();

    // Overrun
    send(8'h11, 1'b1, 1'b0, 0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 0, 1'b0);
    chk("ovr_dout", bus.dout, 8'h11);
    chk("ovr_flag", bus.ovr, 1);
    chk("ovr_dvalid", bus.dvalid, 1);
    ack_one();
    chk("ovr_ack_dvalid", bus.dvalid, 0);
    chk("ovr_ack_flag", bus.ovr, 0);

    // Same-edge ack and delivery
    send(8'h11, 1'b1, 1'b0, 0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 0, 1'b1);
    chk("same_dout", bus.dout, 8'h22);
    chk("same_dvalid", bus.dvalid, 1);
    chk("same_ovr", bus.ovr, 0);
    ack_one();

`ifdef MIOC_DESER_PARITY_EN
    send(8'h07, 1'b1, 1'b1, 0, 1'b0);
    chk("par_perr", bus.perr, 1);
    chk("par_dvalid", bus.dvalid, 0);
    chk("par_dout", bus.dout, 8'h22);
    send(8'h07, 1'b1, 1'b0, 0, 1'b0);
    chk("par_ok_dout", bus.dout, 8'h07);
    chk("par_ok_dvalid", bus.dvalid, 1);
    chk("par_ok_perr", bus.perr, 0);
    ack_one();
`else
    chk("noparity_perr", bus.perr, 0);
`endif

    // Random frames scored by the monitor
    rnd_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      w = W'($urandom);
      bad = ($urandom_range(5) == 0);
`ifdef MIOC_DESER_PARITY_EN
      flip = ($urandom_range(5) == 0);
`else
      flip = 1'b0;
`endif
      if (!bad && !flip) exp_q.push_back(w);
      send(w, !bad, flip, 30, 1'b0);
      chk("rnd_ferr", bus.ferr, bad);
      chk("rnd_ovr", bus.ovr, 0);
`ifdef MIOC_DESER_PARITY_EN
      chk("rnd_perr", bus.perr, flip);
`endif
      for (int g = 0; g < int'($urandom_range(3)); g++) tick(1'b1, 1'($urandom_range(1)));
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    chk("rnd_queue_left", exp_q.size(), 0);
    chk("rnd_end_dvalid", bus.dvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
